uart_tx_scheduler: RTL
======================

// Module: uart_tx_scheduler
// PURPOSE
// - Shares the debug core's single UART byte transmitter between N frame sources (signal dump, OP_OK ping reply, breakpoint notify, ...).
// - Grants one source per frame with round-robin arbitration and streams that source's bytes to the transmitter until the source flags last.
// - Sits between the debug-unit message generators and the UART TX bit engine.
// PARAMETERS
// - N_SRC      4    number of frame sources (2..8)
// - FRAME_MAX  16   max bytes per frame; reaching it forces release and flags overrun
// - CNT_W      5    byte-counter width, >= clog2(FRAME_MAX+1)
// PORTS
// - clk          in   1        system clock (100MHz)
// - rst_n        in   1        asynchronous active-low reset
// - hold         in   1        1 = grant no new frame; a frame in flight still completes
// - src_req      in   N_SRC    per-source level request; held high for the whole frame
// - src_data     in   8*N_SRC  per-source current byte; src i = src_data[8*i+:8], stable while req
// - src_last     in   N_SRC    per-source: current byte is the frame's final byte
// - src_ack      out  N_SRC    one-cycle pulse: granted source's current byte was sent; advance
// - grant        out  N_SRC    one-hot owner of the transmitter; 0 when idle
// - tx_start     out  1        one-cycle pulse: transmitter loads tx_byte
// - tx_byte      out  8        byte to transmit; stable from tx_start until tx_done
// - tx_done      in   1        one-cycle pulse from transmitter: byte (incl. stop bit) sent
// - busy         out  1        1 whenever state != IDLE
// - frame_abort  out  1        one-cycle pulse: granted source dropped req mid-frame
// - overrun      out  1        sticky: a frame hit FRAME_MAX without last; cleared by reset only
// BEHAVIOUR
// - Reset: state=IDLE, rr_ptr=0, grant=0, tx_start=0, tx_byte=8'h00, src_ack=0, busy=0,
//   frame_abort=0, overrun=0, byte_cnt=0. Reset mid-frame drops the frame; no ack is issued.
// - All outputs are registered.
// - IDLE: if ~hold & |src_req: grant <= first requester at or after rr_ptr (wrapping modulo N_SRC); byte_cnt <= 0; -> LOAD.
// - LOAD: if src_req[g]: tx_byte <= src_data[g], tx_start <= 1, last_q <= src_last[g]; -> WAIT.
//   else: frame_abort <= 1, grant <= 0, rr_ptr <= g+1; -> IDLE.
// - WAIT: tx_start low (one-cycle pulse). On tx_done: src_ack[g] <= 1 for one cycle, byte_cnt <= byte_cnt+1.
//   - If last_q: release.
//   - Else if byte_cnt+1 == FRAME_MAX: overrun <= 1, release.
//   - Else -> LOAD.
// - Release: grant <= 0, rr_ptr <= g+1 (wraps N_SRC-1 -> 0); -> IDLE.
// - Latency:
//   - req seen in IDLE at cycle t: grant at t+1, tx_start at t+2.
//   - tx_done at cycle u: src_ack at u+1; next tx_start at u+2 (source has one cycle to present the next byte).
// - src_req dropped during WAIT is ignored until the next LOAD; the byte in flight always completes.
// - tx_done outside WAIT is ignored. hold is sampled only in IDLE.
// - Fairness: a source that just released is lowest priority in the next IDLE decision.
// - tx_done, src_req drop and hold rising in the same cycle: tx_done is processed; the drop is detected at LOAD.
// STRUCTURE
// - definitions.v gains: UART_LEN (8), SCHED_IDLE/LOAD/WAIT state codes (2 bits), default FRAME_MAX.
//   OP_* opcodes stay shared there for the source generators.
// - Sub-module rr_arbiter (combinational): inputs req[N_SRC], ptr; output one-hot pick; reused by any future bus arbiter.
// - Top level holds the FSM, byte counter, rr_ptr, last_q and the output registers.
// TESTING
// - Single source 0, 3-byte frame 8'h01,8'hAA,8'h55 (last on 3rd) -> tx_byte sequence 01,AA,55; 3 src_ack[0] pulses; grant back to 0; rr_ptr=1.
// - src_req=4'b1011 held, rr_ptr=0, 1-byte frames -> grant order 0001,0010,1000,0001; no source granted twice in a row.
// - hold=1 with src_req=4'b0100 -> grant stays 0 and no tx_start; hold released -> grant=0100 at t+1, tx_start at t+2.
// - Source 2 drops req after its 1st of 4 bytes -> that byte completes and is acked; frame_abort pulses; grant=0; next requester is served.
// - FRAME_MAX=16, source never asserts last -> exactly 16 tx_start pulses; overrun=1 and stays 1; grant released.
// - rst_n low during WAIT of the 2nd byte -> all outputs return to reset values immediately; stray tx_done after reset -> ignored.

Source files
------------

// File: rtl/uart_tx_scheduler_pkg.sv
// Shared definitions for the UART TX frame scheduler.
// Holds the transmitted byte width, the scheduler state codes and the
// default frame geometry used by the top-level parameters.
package uart_tx_scheduler_pkg;

   localparam int unsigned UART_LEN      = 8;   // bits per transmitted byte
   localparam int unsigned N_SRC_DEF     = 4;   // default number of frame sources
   localparam int unsigned FRAME_MAX_DEF = 16;  // default max bytes per frame
   localparam int unsigned CNT_W_DEF     = 5;   // default byte-counter width

   typedef enum logic [1:0] {
      SCHED_IDLE = 2'd0,
      SCHED_LOAD = 2'd1,
      SCHED_WAIT = 2'd2
   } sched_state_e;

   // Pointer width for an n-entry round-robin, never less than one bit
   function automatic int unsigned ptr_width(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/uart_tx_scheduler_rr_arbiter.sv
// Combinational round-robin picker.
// Ports:
//   i_req  [N]      request vector
//   i_ptr  [PTR_W]  highest-priority index (must be < N)
//   o_pick [N]      one-hot first requester at or after i_ptr, wrapping; 0 if none
module uart_tx_scheduler_rr_arbiter #(
   parameter int unsigned N     = 4,
   parameter int unsigned PTR_W = 2
) (
   input  logic [N-1:0]     i_req,
   input  logic [PTR_W-1:0] i_ptr,
   output logic [N-1:0]     o_pick
);

   // Scan N positions starting at i_ptr; the first hit wins
   always_comb begin
      logic found;
      int   idx;
      o_pick = '0;
      found  = 1'b0;
      idx    = 0;
      for (int k = 0; k < int'(N); k++) begin
         idx = int'(i_ptr) + k;
         if (idx >= int'(N)) idx = idx - int'(N);
         if (!found && i_req[idx]) begin
            o_pick[idx] = 1'b1;
            found       = 1'b1;
         end
      end
   end

endmodule

// File: rtl/uart_tx_scheduler.sv
// Shares one UART byte transmitter between N_SRC frame sources.
// A source is granted for a whole frame (round-robin between frames) and its
// bytes are streamed to the transmitter until it flags last, drops its
// request, or the frame reaches FRAME_MAX bytes.
// Ports:
//   clk, rst_n                 clock, async active-low reset
//   hold                       block new grants (sampled in IDLE only)
//   src_req/src_data/src_last  per-source request, current byte, last flag
//   src_ack                    pulse: granted source's byte was sent
//   grant                      one-hot transmitter owner
//   tx_start/tx_byte/tx_done   transmitter handshake
//   busy, frame_abort, overrun status
module uart_tx_scheduler
   import uart_tx_scheduler_pkg::*;
#(
   parameter int unsigned N_SRC     = N_SRC_DEF,
   parameter int unsigned FRAME_MAX = FRAME_MAX_DEF,
   parameter int unsigned CNT_W     = CNT_W_DEF
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      hold,
   input  logic [N_SRC-1:0]          src_req,
   input  logic [UART_LEN*N_SRC-1:0] src_data,
   input  logic [N_SRC-1:0]          src_last,
   output logic [N_SRC-1:0]          src_ack,
   output logic [N_SRC-1:0]          grant,
   output logic                      tx_start,
   output logic [UART_LEN-1:0]       tx_byte,
   input  logic                      tx_done,
   output logic                      busy,
   output logic                      frame_abort,
   output logic                      overrun
);

   localparam int unsigned PTR_W = ptr_width(N_SRC);

   sched_state_e          r_state,       w_state_nxt;
   logic [PTR_W-1:0]      r_rr_ptr,      w_rr_ptr_nxt;
   logic [PTR_W-1:0]      r_gidx,        w_gidx_nxt;
   logic [N_SRC-1:0]      r_grant,       w_grant_nxt;
   logic [N_SRC-1:0]      r_src_ack,     w_src_ack_nxt;
   logic                  r_tx_start,    w_tx_start_nxt;
   logic [UART_LEN-1:0]   r_tx_byte,     w_tx_byte_nxt;
   logic                  r_frame_abort, w_frame_abort_nxt;
   logic                  r_overrun,     w_overrun_nxt;
   logic                  r_busy;
   logic                  r_last_q,      w_last_q_nxt;
   logic [CNT_W-1:0]      r_byte_cnt,    w_byte_cnt_nxt;

   logic [N_SRC-1:0]      w_pick;
   logic [PTR_W-1:0]      w_pick_idx;
   logic [UART_LEN-1:0]   w_sel_byte;
   logic                  w_sel_last;
   logic                  w_sel_req;
   logic [CNT_W-1:0]      w_cnt_inc;
   logic [PTR_W-1:0]      w_ptr_after;

   uart_tx_scheduler_rr_arbiter #(
      .N     (N_SRC),
      .PTR_W (PTR_W)
   ) u_rr_arbiter (
      .i_req  (src_req),
      .i_ptr  (r_rr_ptr),
      .o_pick (w_pick)
   );

   // Encode the arbiter pick and select the granted source's byte/last
   always_comb begin
      w_pick_idx = '0;
      w_sel_byte = '0;
      w_sel_last = 1'b0;
      for (int i = 0; i < int'(N_SRC); i++) begin
         if (w_pick[i]) w_pick_idx = PTR_W'(i);
         if (r_grant[i]) begin
            w_sel_byte = src_data[i*UART_LEN +: UART_LEN];
            w_sel_last = src_last[i];
         end
      end
   end

   assign w_sel_req   = |(src_req & r_grant);
   assign w_cnt_inc   = r_byte_cnt + CNT_W'(1);
   // Released source becomes lowest priority next time
   assign w_ptr_after = (r_gidx == PTR_W'(N_SRC - 1)) ? '0 : r_gidx + PTR_W'(1);

   // Next-state and next-output logic
   always_comb begin
      w_state_nxt       = r_state;
      w_rr_ptr_nxt      = r_rr_ptr;
      w_gidx_nxt        = r_gidx;
      w_grant_nxt       = r_grant;
      w_src_ack_nxt     = '0;
      w_tx_start_nxt    = 1'b0;
      w_tx_byte_nxt     = r_tx_byte;
      w_frame_abort_nxt = 1'b0;
      w_overrun_nxt     = r_overrun;
      w_last_q_nxt      = r_last_q;
      w_byte_cnt_nxt    = r_byte_cnt;

      case (r_state)
         SCHED_IDLE: begin
            if (!hold && (|src_req)) begin
               w_grant_nxt    = w_pick;
               w_gidx_nxt     = w_pick_idx;
               w_byte_cnt_nxt = '0;
               w_state_nxt    = SCHED_LOAD;
            end
         end
         SCHED_LOAD: begin
            if (w_sel_req) begin
               w_tx_byte_nxt  = w_sel_byte;
               w_tx_start_nxt = 1'b1;
               w_last_q_nxt   = w_sel_last;
               w_state_nxt    = SCHED_WAIT;
            end else begin
               w_frame_abort_nxt = 1'b1;
               w_grant_nxt       = '0;
               w_rr_ptr_nxt      = w_ptr_after;
               w_state_nxt       = SCHED_IDLE;
            end
         end
         SCHED_WAIT: begin
            if (tx_done) begin
               w_src_ack_nxt  = r_grant;
               w_byte_cnt_nxt = w_cnt_inc;
               if (r_last_q || (w_cnt_inc == CNT_W'(FRAME_MAX))) begin
                  if (!r_last_q) w_overrun_nxt = 1'b1;
                  w_grant_nxt  = '0;
                  w_rr_ptr_nxt = w_ptr_after;
                  w_state_nxt  = SCHED_IDLE;
               end else begin
                  w_state_nxt  = SCHED_LOAD;
               end
            end
         end
         default: w_state_nxt = SCHED_IDLE;
      endcase
   end

   // State and output registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state       <= SCHED_IDLE;
         r_rr_ptr      <= '0;
         r_gidx        <= '0;
         r_grant       <= '0;
         r_src_ack     <= '0;
         r_tx_start    <= 1'b0;
         r_tx_byte     <= '0;
         r_frame_abort <= 1'b0;
         r_overrun     <= 1'b0;
         r_busy        <= 1'b0;
         r_last_q      <= 1'b0;
         r_byte_cnt    <= '0;
      end else begin
         r_state       <= w_state_nxt;
         r_rr_ptr      <= w_rr_ptr_nxt;
         r_gidx        <= w_gidx_nxt;
         r_grant       <= w_grant_nxt;
         r_src_ack     <= w_src_ack_nxt;
         r_tx_start    <= w_tx_start_nxt;
         r_tx_byte     <= w_tx_byte_nxt;
         r_frame_abort <= w_frame_abort_nxt;
         r_overrun     <= w_overrun_nxt;
         r_busy        <= (w_state_nxt != SCHED_IDLE);
         r_last_q      <= w_last_q_nxt;
         r_byte_cnt    <= w_byte_cnt_nxt;
      end
   end

   assign src_ack     = r_src_ack;
   assign grant       = r_grant;
   assign tx_start    = r_tx_start;
   assign tx_byte     = r_tx_byte;
   assign busy        = r_busy;
   assign frame_abort = r_frame_abort;
   assign overrun     = r_overrun;

endmodule
